instruction_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Owns the program counter and drives the synchronous instruction memory, which has 1-cycle read latency.
- Presents the IF/ID instruction word, its PC and a valid flag to the decoder.
- Handles hazard-unit stalls and branch redirects, and squashes wrong-path fetches by substituting the NOP encoding.

---
 rtl/instruction_fetch_stage_if.sv | 23 ++
 rtl/instruction_fetch_stage.sv | 49 ++++
 tb/tb_instruction_fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: hazard/branch controls, imem port and IF/ID outputs of the fetch stage
interface instruction_fetch_stage_if #(
  parameter int PC_WIDTH = 32,
  parameter int IMEM_AW  = 8
);
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                imem_en;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [31:0]         imem_data;
  logic [31:0]         ifid_instruction;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic                ifid_valid;
  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_en, imem_addr, ifid_instruction, ifid_pc, ifid_valid
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_en, imem_addr, ifid_instruction, ifid_pc, ifid_valid
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC owner feeding a 1-cycle imem into IF/ID with stall hold and branch squash
module instruction_fetch_stage #(
  parameter int          PC_WIDTH = 32,
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] NOP_WORD = 32'hF000_0000
) (
  input logic clk,
  input logic reset,
  instruction_fetch_stage_if.master bus
);
  logic [PC_WIDTH-1:0] pc, fetch_pc, hold_pc;
  logic                fetch_valid, hold_valid;
  logic [31:0]         hold_instr;
  // held word wins over the in-flight read; with neither present a NOP bubble is shown
  always_comb begin
    bus.ifid_instruction = hold_valid ? hold_instr : fetch_valid ? bus.imem_data : NOP_WORD;
    bus.ifid_pc          = hold_valid ? hold_pc : fetch_pc;
    bus.ifid_valid       = hold_valid | fetch_valid;
    bus.imem_en          = ~bus.stall | bus.branch_taken;
    bus.imem_addr        = pc[IMEM_AW+1:2];
  end
  // PC advance, branch redirect with squash, and capture of the live word on the first stalled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
      hold_instr  <= NOP_WORD;
      hold_pc     <= '0;
    end else if (bus.branch_taken) begin
      pc          <= bus.branch_target & ~PC_WIDTH'(3);
      fetch_valid <= 1'b0;
      hold_valid  <= 1'b0;
    end else if (bus.stall) begin
      fetch_valid <= 1'b0;
      if (!hold_valid && fetch_valid) begin
        hold_valid <= 1'b1;
        hold_instr <= bus.imem_data;
        hold_pc    <= fetch_pc;
      end
    end else begin
      fetch_pc    <= pc;
      pc          <= pc + PC_WIDTH'(4);
      fetch_valid <= 1'b1;
      hold_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: randomized scoreboard bench for the fetch stage against a program-order model
module tb_instruction_fetch_stage;
  localparam logic [31:0] NOP = 32'hF000_0000;
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [7:0]  addr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] mem [256];
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  bit known = 1'b0;
  logic        m_v = 1'b0;
  logic [31:0] m_disp_pc = '0, m_pc = '0, m_last = '0;
  bit done = 1'b0;
  instruction_fetch_stage_if #(.PC_WIDTH(32), .IMEM_AW(8)) bus ();
  instruction_fetch_stage #(.PC_WIDTH(32), .IMEM_AW(8), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] i;
    i = a[9:2];
    return mem[i];
  endfunction
  // one cycle: record what the stage should show now, apply inputs, then advance the model
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    @(posedge clk);
    #1;
    if (known) begin
      e.v = m_v;
      e.pc = m_disp_pc;
      e.ins = m_v ? word_at(m_disp_pc) : NOP;
      e.addr = m_pc[9:2];
      q.push_back(e);
    end
    reset = r;
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    #1;
    compared++;
    if (bus.imem_en !== (~s | b)) begin
      mismatched++;
      $display("FAIL imem_en: got %b expected %b", bus.imem_en, ~s | b);
    end
    if (r) begin
      m_v = 0; m_disp_pc = 0; m_pc = 0; m_last = 0; known = 1;
    end else if (b) begin
      m_v = 0; m_disp_pc = m_last; m_pc = t & ~32'd3;
    end else if (!s) begin
      m_v = 1; m_disp_pc = m_pc; m_last = m_pc; m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  // monitor: pops the expectation for the current cycle mid-period and compares every output
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        compared++;
        if (bus.ifid_valid !== e.v || bus.ifid_pc !== e.pc || bus.ifid_instruction !== e.ins ||
            bus.imem_addr !== e.addr) begin
          mismatched++;
          $display("FAIL ifid: got v=%b pc=%h ins=%h addr=%h expected v=%b pc=%h ins=%h addr=%h",
                   bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction, bus.imem_addr,
                   e.v, e.pc, e.ins, e.addr);
        end
      end
    end
  end
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'hA800_0000 + k;
    bus.stall = 0;
    bus.branch_taken = 0;
    bus.branch_target = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    run(3);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    run(4);
    step(0, 1, 1, 32'h23);
    run(4);
    step(0, 0, 1, 32'h100);
    step(0, 0, 1, 32'h80);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run(3);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    run(3);
    step(0, 0, 1, 32'hFFFF_FFFC);
    run(4);
    step(0, 1, 1, 32'hFFFF_FFF9);
    run(3);
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b;
      logic [31:0] t;
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 10);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step(r, s, b, t);
    end
    run(2);
    @(posedge clk);
    @(posedge clk);
    done = 1;
    @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
